// File: rtl/score_pkg.sv
// score_pkg
// Shared definitions for the score accumulator slice.
//   MAX_PTS       largest point value a single event can carry
//   team_w()      width of a team index for a given team count
//   hist_t        single-level undo record {team, applied delta, valid}
//   applied_delta saturated delta actually applied by a point event
package score_pkg;

    localparam int MAX_PTS = 3;

    // History fields are sized for the largest supported configuration;
    // the top level checks at elaboration that its parameters fit.
    localparam int HIST_TEAM_W  = 8;
    localparam int HIST_DELTA_W = 16;

    typedef struct packed {
        logic [HIST_TEAM_W-1:0]         team;
        logic signed [HIST_DELTA_W-1:0] delta;
        logic                           valid;
    } hist_t;

    function automatic int team_w(input int n_teams);
        int w;
        w = $clog2(n_teams);
        return (w < 1) ? 1 : w;
    endfunction

    // Delta that a saturating add/subtract really applies to 'cur'.
    // Storing this (not the requested value) makes undo an exact restore.
    function automatic int applied_delta(input int cur, input int pts,
                                         input logic sub, input int max_score);
        if (sub)
            return (pts > cur) ? -cur : -pts;
        else
            return (cur + pts > max_score) ? (max_score - cur) : pts;
    endfunction

endpackage

// File: rtl/score_channel.sv
// score_channel
// One saturating score register with its sticky saturation flag.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   clr          synchronous clear of score and sat
//   en           apply a point event (val points, add or subtract)
//   sub          1 = subtract, 0 = add
//   val          points 0..MAX_PTS
//   force_en     undo: move the score back by force_delta
//   force_delta  signed delta previously applied to this channel
//   score        current score
//   sat          set when an add was clipped at MAX_SCORE
module score_channel
    import score_pkg::*;
#(
    parameter int SCORE_W   = 7,
    parameter int MAX_SCORE = 99
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    input  logic                           sub,
    input  logic [1:0]                     val,
    input  logic                           force_en,
    input  logic signed [HIST_DELTA_W-1:0] force_delta,
    output logic [SCORE_W-1:0]             score,
    output logic                           sat
);

    localparam int RW = HIST_DELTA_W + 1;
    localparam logic [SCORE_W:0]         MAX_W = (SCORE_W+1)'(MAX_SCORE);
    localparam logic signed [RW-1:0]     MAX_R = RW'(MAX_SCORE);

    logic [SCORE_W:0]     wide;
    logic [SCORE_W:0]     val_w;
    logic [SCORE_W:0]     sum;
    logic signed [RW-1:0] restored;
    logic [SCORE_W-1:0]   next_score;
    logic                 clip;

    // Arithmetic is one bit wider than the register so an add past the
    // ceiling or a subtract below zero is seen and clamped, never wrapped.
    always_comb begin
        wide       = {1'b0, score};
        val_w      = (SCORE_W+1)'(val);
        sum        = wide + val_w;
        restored   = signed'(RW'(score)) - RW'(force_delta);
        next_score = score;
        clip       = 1'b0;
        if (force_en) begin
            if (restored < 0)
                next_score = '0;
            else if (restored > MAX_R)
                next_score = MAX_W[SCORE_W-1:0];
            else
                next_score = restored[SCORE_W-1:0];
        end else if (en) begin
            if (sub) begin
                if (wide < val_w)
                    next_score = '0;
                else
                    next_score = SCORE_W'(wide - val_w);
            end else if (sum > MAX_W) begin
                next_score = MAX_W[SCORE_W-1:0];
                clip       = 1'b1;
            end else begin
                next_score = sum[SCORE_W-1:0];
            end
        end
    end

    // sat is sticky: only reset or clear drop it, undo leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            score <= '0;
            sat   <= 1'b0;
        end else begin
            score <= next_score;
            if (clip)
                sat <= 1'b1;
        end
    end

endmodule

// File: rtl/score_accumulator.sv
// score_accumulator
// Per-team saturating scores with add/correct events, single-level undo
// and a combinational leader/tie indication.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   clr         synchronous clear of scores, sat flags and history
//   pts_valid   one-cycle point-event strobe
//   pts_team    target team index
//   pts_val     points 0..3
//   pts_sub     1 = subtract (correction), 0 = add
//   undo        one-cycle request to revert the last applied event
//   score       packed scores, team 0 in the LSBs
//   sat         sticky per-team saturation flags
//   ack, err    one-cycle pulses: request applied / rejected
//   lead        index of highest score, lowest index on ties
//   tie         top score shared by two or more teams
module score_accumulator
    import score_pkg::*;
#(
    parameter int  N_TEAMS   = 2,
    parameter int  SCORE_W   = 7,
    parameter int  MAX_SCORE = 99,
    localparam int TEAM_W    = team_w(N_TEAMS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       pts_valid,
    input  logic [TEAM_W-1:0]          pts_team,
    input  logic [1:0]                 pts_val,
    input  logic                       pts_sub,
    input  logic                       undo,
    output logic [N_TEAMS*SCORE_W-1:0] score,
    output logic [N_TEAMS-1:0]         sat,
    output logic                       ack,
    output logic                       err,
    output logic [TEAM_W-1:0]          lead,
    output logic                       tie
);

    if (MAX_SCORE > (2**SCORE_W) - 1 || N_TEAMS < 2 ||
        TEAM_W > HIST_TEAM_W || SCORE_W >= HIST_DELTA_W) begin : g_param_check
        $error("score_accumulator: illegal parameter combination");
    end

    logic [SCORE_W-1:0] score_arr [N_TEAMS];
    logic [SCORE_W-1:0] cur_score;
    logic               team_ok;
    logic               evt_apply;
    logic               undo_apply;
    int                 pts_delta;
    hist_t              hist;

    // When the index width can encode more values than there are teams,
    // out-of-range indices must be rejected; otherwise every index is valid.
    if ((1 << TEAM_W) > N_TEAMS) begin : g_team_range
        assign team_ok = (pts_team < TEAM_W'(N_TEAMS));
    end else begin : g_team_full
        assign team_ok = 1'b1;
    end

    // A zero-point event is acknowledged but touches neither score nor history.
    assign evt_apply  = !clr && !undo && pts_valid && team_ok && (pts_val != 2'd0);
    assign undo_apply = !clr && undo && hist.valid;

    always_comb begin
        cur_score = '0;
        for (int i = 0; i < N_TEAMS; i++) begin
            if (pts_team == TEAM_W'(i))
                cur_score = score_arr[i];
        end
        pts_delta = applied_delta(int'(cur_score), int'(pts_val), pts_sub, MAX_SCORE);
    end

    for (genvar g = 0; g < N_TEAMS; g++) begin : g_chan
        score_channel #(
            .SCORE_W   (SCORE_W),
            .MAX_SCORE (MAX_SCORE)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .clr         (clr),
            .en          (evt_apply && (pts_team == TEAM_W'(g))),
            .sub         (pts_sub),
            .val         (pts_val),
            .force_en    (undo_apply && (hist.team == HIST_TEAM_W'(g))),
            .force_delta (hist.delta),
            .score       (score_arr[g]),
            .sat         (sat[g])
        );
        assign score[g*SCORE_W +: SCORE_W] = score_arr[g];
    end

    // Request priority is clr > undo > pts_valid. A point event that
    // collides with undo is dropped and reported, so ack and err can
    // both pulse in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack  <= 1'b0;
            err  <= 1'b0;
            hist <= '0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (clr) begin
                hist <= '0;
            end else if (undo) begin
                if (hist.valid) begin
                    ack        <= 1'b1;
                    hist.valid <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
                if (pts_valid)
                    err <= 1'b1;
            end else if (pts_valid) begin
                if (team_ok) begin
                    ack <= 1'b1;
                    if (pts_val != 2'd0) begin
                        hist.team  <= HIST_TEAM_W'(pts_team);
                        hist.delta <= HIST_DELTA_W'(pts_delta);
                        hist.valid <= 1'b1;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    // Strict '>' keeps the lowest index on equal scores.
    always_comb begin
        logic [SCORE_W-1:0] best;
        int                 n_top;
        best = score_arr[0];
        lead = '0;
        for (int i = 1; i < N_TEAMS; i++) begin
            if (score_arr[i] > best) begin
                best = score_arr[i];
                lead = TEAM_W'(i);
            end
        end
        n_top = 0;
        for (int i = 0; i < N_TEAMS; i++) begin
            if (score_arr[i] == best)
                n_top++;
        end
        tie = (n_top >= 2);
    end

endmodule

// File: tb/tb_score_accumulator.sv
// tb_score_accumulator
// Directed bench for score_accumulator with three teams, so that an
// out-of-range team index (3) can be presented on the 2-bit index.
module tb_score_accumulator;

    localparam int N_TEAMS   = 3;
    localparam int SCORE_W   = 7;
    localparam int MAX_SCORE = 99;

    logic                       clk;
    logic                       rst;
    logic                       clr;
    logic                       pts_valid;
    logic [1:0]                 pts_team;
    logic [1:0]                 pts_val;
    logic                       pts_sub;
    logic                       undo;
    logic [N_TEAMS*SCORE_W-1:0] score;
    logic [N_TEAMS-1:0]         sat;
    logic                       ack;
    logic                       err;
    logic [1:0]                 lead;
    logic                       tie;

    int errors = 0;
    int checks = 0;

    score_accumulator #(
        .N_TEAMS   (N_TEAMS),
        .SCORE_W   (SCORE_W),
        .MAX_SCORE (MAX_SCORE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .pts_valid (pts_valid),
        .pts_team  (pts_team),
        .pts_val   (pts_val),
        .pts_sub   (pts_sub),
        .undo      (undo),
        .score     (score),
        .sat       (sat),
        .ack       (ack),
        .err       (err),
        .lead      (lead),
        .tie       (tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] team_score(input int t);
        return 32'(score[t*SCORE_W +: SCORE_W]);
    endfunction

    // Drive one cycle of inputs at the falling edge, then land just after
    // the rising edge that consumes them.
    task automatic apply_stimulus(input logic v, input logic [1:0] team,
                                  input logic [1:0] val, input logic sub,
                                  input logic un, input logic c);
        @(negedge clk);
        pts_valid = v;
        pts_team  = team;
        pts_val   = val;
        pts_sub   = sub;
        undo      = un;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        pts_valid = 1'b0;
        pts_team  = '0;
        pts_val   = '0;
        pts_sub   = 1'b0;
        undo      = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("reset_score", 32'(score), 0);
        check_output("reset_sat",   32'(sat),   0);
        check_output("reset_lead",  32'(lead),  0);
        check_output("reset_tie",   32'(tie),   1);
        check_output("reset_ack",   32'(ack),   0);
        check_output("reset_err",   32'(err),   0);

        // Back-to-back adds on different teams
        apply_stimulus(1, 1, 3, 0, 0, 0);
        check_output("b2b_ack1", 32'(ack), 1);
        check_output("b2b_err1", 32'(err), 0);
        apply_stimulus(1, 0, 2, 0, 0, 0);
        check_output("b2b_ack2", 32'(ack), 1);
        check_output("b2b_s1",   team_score(1), 3);
        check_output("b2b_s0",   team_score(0), 2);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("b2b_ack_drop", 32'(ack), 0);
        check_output("b2b_lead", 32'(lead), 1);
        check_output("b2b_tie",  32'(tie),  0);

        // Undo together with a point event: undo wins, event is rejected
        apply_stimulus(1, 1, 3, 0, 0, 0);
        check_output("pre_undo_s1", team_score(1), 6);
        apply_stimulus(1, 0, 2, 0, 1, 0);
        check_output("both_ack", 32'(ack), 1);
        check_output("both_err", 32'(err), 1);
        check_output("both_s1",  team_score(1), 3);
        check_output("both_s0",  team_score(0), 2);

        // Clear with a concurrent event
        apply_stimulus(1, 0, 3, 0, 0, 1);
        check_output("clr_ack",   32'(ack),   0);
        check_output("clr_err",   32'(err),   0);
        check_output("clr_score", 32'(score), 0);
        check_output("clr_tie",   32'(tie),   1);

        // Drive team 0 to 98, then clip at the ceiling
        for (int i = 0; i < 32; i++)
            apply_stimulus(1, 0, 3, 0, 0, 0);
        apply_stimulus(1, 0, 2, 0, 0, 0);
        check_output("s0_98",     team_score(0), 98);
        check_output("s0_98_sat", 32'(sat), 0);
        apply_stimulus(1, 0, 3, 0, 0, 0);
        check_output("clip_s0",  team_score(0), 99);
        check_output("clip_sat", 32'(sat), 1);
        check_output("clip_ack", 32'(ack), 1);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        check_output("undo_clip_s0",  team_score(0), 98);
        check_output("undo_clip_sat", 32'(sat), 1);
        check_output("undo_clip_ack", 32'(ack), 1);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        check_output("undo2_err", 32'(err), 1);
        check_output("undo2_ack", 32'(ack), 0);
        check_output("undo2_s0",  team_score(0), 98);

        // Subtract below zero clamps, undo restores exactly
        apply_stimulus(1, 1, 1, 0, 0, 0);
        check_output("s1_one", team_score(1), 1);
        apply_stimulus(1, 1, 2, 1, 0, 0);
        check_output("sub_clamp_s1", team_score(1), 0);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        check_output("undo_sub_s1",  team_score(1), 1);
        check_output("undo_sub_ack", 32'(ack), 1);

        // Zero points: acknowledged, history untouched (still empty)
        apply_stimulus(1, 1, 0, 0, 0, 0);
        check_output("zero_ack", 32'(ack), 1);
        check_output("zero_s1",  team_score(1), 1);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        check_output("zero_undo_err", 32'(err), 1);

        // Out-of-range team
        apply_stimulus(1, 3, 3, 0, 0, 0);
        check_output("bad_team_err",   32'(err), 1);
        check_output("bad_team_ack",   32'(ack), 0);
        check_output("bad_team_score", 32'(score), (1 << 7) + 98);
        check_output("bad_team_lead",  32'(lead), 0);

        // Reset in the middle of a burst acts immediately
        apply_stimulus(1, 2, 3, 0, 0, 0);
        check_output("burst_s2", team_score(2), 3);
        @(negedge clk);
        pts_team = 2'd2;
        #2 rst = 1'b1;
        #1;
        check_output("async_rst_score", 32'(score), 0);
        check_output("async_rst_sat",   32'(sat),   0);
        check_output("async_rst_ack",   32'(ack),   0);
        check_output("async_rst_tie",   32'(tie),   1);
        @(negedge clk);
        rst       = 1'b0;
        pts_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("post_rst_score", 32'(score), 0);
        check_output("post_rst_ack",   32'(ack),   0);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        check_output("post_rst_undo_err", 32'(err), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
